pe_code_decoder: RTL and testbench
==================================

// Module: pe_code_decoder
// PURPOSE
//  Receive end of the 3-input priority-encoder interface: takes the 2-bit code {out1,out0}
//  (00 none, 01 in0, 10 in1, 11 in2) and regenerates a one-hot request line.
//  The decoded line is held for a programmable number of cycles (pulse stretch).
//  A valid/ready handshake paces the upstream encoder.
//  Sits between the registered encoder output and the downstream per-line consumers.
// PARAMETERS
//  HOLD_CYCLES  4  cycles a decoded line stays high; legal range 1..255
//  CNT_W        8  width of per-line event counters (used only with PE_DEC_COUNT_EN)
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst         in   1      asynchronous, active-high reset
//  code        in   2      encoded request {out1,out0}
//  code_valid  in   1      code is valid this cycle
//  code_ready  out  1      block can accept a code this cycle
//  dec_out     out  3      one-hot decoded line: bit0=in0, bit1=in1, bit2=in2
//  busy        out  1      high while a line is held or in the gap cycle
// BEHAVIOUR
//  - One clock (clk); reset rst is asynchronous, active-high.
//  - Reset: state=IDLE, dec_out=000, busy=0, hold counter=0, event counters=0;
//    code_ready=0 while rst is high; rises combinationally once rst is released.
//  - code_ready = (state==IDLE) & ~rst. Transfer = code_valid & code_ready at a rising edge.
//  - FSM states: IDLE, HOLD, GAP.
//    IDLE: on transfer with code!=00 -> dec_out <= one-hot(code), hold counter <= HOLD_CYCLES-1,
//          go HOLD. Transfer with code==00: accepted, dropped; stay IDLE, dec_out=000.
//    HOLD: code_ready=0, dec_out held; counter decrements each cycle; counter==0 -> dec_out<=000, go GAP.
//    GAP:  exactly one cycle, dec_out=000, code_ready=0; go IDLE.
//  - Timing: transfer at edge t0 -> dec_out one-hot for cycles t0+1..t0+HOLD_CYCLES,
//    000 at t0+HOLD_CYCLES+1 (GAP), code_ready=1 from t0+HOLD_CYCLES+2.
//    HOLD_CYCLES=1 gives a single-cycle pulse.
//  - dec_out is registered; never more than one bit high; never high outside HOLD.
//  - busy = (state != IDLE), registered along with state.
//  - code_valid held high while not ready: no transfer, code is ignored. The code sampled is the
//    value present at the edge where code_ready is high.
//  - Reset mid-HOLD or mid-GAP: dec_out drops to 000 asynchronously, state IDLE,
//    counter cleared; no pending request is remembered.
//  - Codes are sampled only at a transfer; changes on code outside a transfer have no effect.
// CONFIGURATION
//  Macro PE_DEC_COUNT_EN:
//   defined: extra outputs cnt0, cnt1, cnt2 (out, CNT_W each). cntN increments by 1 on every
//     transfer of the code for line N (01->cnt0, 10->cnt1, 11->cnt2), saturating at all-ones,
//     cleared by rst; code 00 is not counted. Counters are registered, updated at transfer edge.
//   undefined: counter ports and logic absent; all other behaviour identical.
// TESTING
//  1. Assert rst, release -> dec_out=000, busy=0, code_ready=0 during reset, 1 after release.
//  2. HOLD_CYCLES=4, transfer code=11 at t0 -> dec_out=100 cycles t0+1..t0+4, 000 at t0+5,
//     busy=1 t0+1..t0+5, code_ready=1 at t0+6.
//  3. Transfer code=00 in IDLE -> dec_out stays 000, busy stays 0, code_ready stays 1.
//  4. Hold code_valid=1, code=01 throughout test 2's HOLD -> no transfer until code_ready=1 at t0+6;
//     then dec_out=001 at t0+7 for 4 cycles.
//  5. Transfer code=10, assert rst at 2nd HOLD cycle -> dec_out=000 immediately (same cycle);
//     after release state IDLE, code_ready=1, no resumed pulse.
//  6. PE_DEC_COUNT_EN, CNT_W=8, HOLD_CYCLES=1: 300 transfers of code=01 -> cnt0=255 (saturated),
//     cnt1=cnt2=0; without macro the same stimulus compiles and the dec_out waveform is unchanged.

Source files
------------

// File: rtl/pe_code_decoder.sv
// Regenerates a stretched one-hot request line from a 2-bit priority-encoder code.
// Optional per-line saturating event counters are enabled with `define PE_DEC_COUNT_EN.
module pe_code_decoder #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       code,
  input  logic             code_valid,
  output logic             code_ready,
  output logic [2:0]       dec_out,
`ifdef PE_DEC_COUNT_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StHold = 2'b01,
    StGap  = 2'b10
  } state_e;

  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] dec_q, dec_d;
  logic       busy_q, busy_d;
  logic       xfer;
  logic [2:0] code_onehot;

  assign code_ready = (state_q == StIdle) & ~rst;
  assign xfer       = code_valid & code_ready;

  // Code 00 maps to no line at all, so it is accepted but never raises dec_out.
  always_comb begin
    code_onehot = 3'b000;
    unique case (code)
      2'b01:   code_onehot = 3'b001;
      2'b10:   code_onehot = 3'b010;
      2'b11:   code_onehot = 3'b100;
      default: code_onehot = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dec_d   = dec_q;
    unique case (state_q)
      StIdle: begin
        dec_d = 3'b000;
        if (xfer && (code != 2'b00)) begin
          dec_d   = code_onehot;
          hold_d  = HoldLoad;
          state_d = StHold;
        end
      end
      StHold: begin
        if (hold_q == 8'd0) begin
          dec_d   = 3'b000;
          state_d = StGap;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      StGap: begin
        dec_d   = 3'b000;
        state_d = StIdle;
      end
      default: begin
        dec_d   = 3'b000;
        hold_d  = 8'd0;
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= 8'd0;
      dec_q   <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
    end
  end

  assign dec_out = dec_q;
  assign busy    = busy_q;

`ifdef PE_DEC_COUNT_EN
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      for (int i = 0; i < 3; i++) begin
        if (code_onehot[i] && !(&cnt_q[i])) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_pe_code_decoder.sv
// Directed bench for pe_code_decoder: one instance at HOLD_CYCLES=4, one at HOLD_CYCLES=1.
module tb_pe_code_decoder;

  logic       clk;
  logic       rst;
  logic [1:0] code, code1;
  logic       code_valid, code_valid1;
  logic       code_ready, code_ready1;
  logic [2:0] dec_out, dec_out1;
  logic       busy, busy1;
`ifdef PE_DEC_COUNT_EN
  logic [7:0] cnt0, cnt1, cnt2;
  logic [7:0] c1_0, c1_1, c1_2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  pe_code_decoder #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .dec_out    (dec_out),
`ifdef PE_DEC_COUNT_EN
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .cnt2       (cnt2),
`endif
    .busy       (busy)
  );

  pe_code_decoder #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .code       (code1),
    .code_valid (code_valid1),
    .code_ready (code_ready1),
    .dec_out    (dec_out1),
`ifdef PE_DEC_COUNT_EN
    .cnt0       (c1_0),
    .cnt1       (c1_1),
    .cnt2       (c1_2),
`endif
    .busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the transfer edge; leaves the bench just after the first ready cycle begins.
  task automatic pulse_check(input string tag, input logic [2:0] exp);
    check({tag, "_dec0"}, 32'(dec_out), 32'(exp));
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    check({tag, "_rdy0"}, 32'(code_ready), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, "_dec"}, 32'(dec_out), 32'(exp));
      check({tag, "_rdy"}, 32'(code_ready), 32'd0);
    end
    tick();
    check({tag, "_gap_dec"}, 32'(dec_out), 32'd0);
    check({tag, "_gap_busy"}, 32'(busy), 32'd1);
    check({tag, "_gap_rdy"}, 32'(code_ready), 32'd0);
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_rdy"}, 32'(code_ready), 32'd1);
    check({tag, "_idle_dec"}, 32'(dec_out), 32'd0);
  endtask

  initial begin
    int pulses;
    int waited;
    rst         = 1'b1;
    code        = 2'b00;
    code_valid  = 1'b0;
    code1       = 2'b01;
    code_valid1 = 1'b0;

    // 1: reset
    #2;
    check("rst_rdy", 32'(code_ready), 32'd0);
    check("rst_dec", 32'(dec_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rel_rdy", 32'(code_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);

    // 2: code 11 -> line 2 stretched 4 cycles, one gap cycle
    code = 2'b11; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    pulse_check("t2", 3'b100);

    // 3: code 00 accepted and dropped
    code = 2'b00; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    check("t3_dec", 32'(dec_out), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_rdy", 32'(code_ready), 32'd1);

    // 4: valid held through the pulse; code 01 taken only once ready returns
    code = 2'b11; code_valid = 1'b1;
    tick();
    code = 2'b01;
    pulse_check("t4a", 3'b100);
    tick();
    code_valid = 1'b0;
    pulse_check("t4b", 3'b001);

`ifdef PE_DEC_COUNT_EN
    check("cnt0", 32'(cnt0), 32'd1);
    check("cnt1", 32'(cnt1), 32'd0);
    check("cnt2", 32'(cnt2), 32'd2);
`endif

    // 5: reset in the second hold cycle clears the line asynchronously
    code = 2'b10; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    check("t5_dec1", 32'(dec_out), 32'b010);
    tick();
    check("t5_dec2", 32'(dec_out), 32'b010);
    rst = 1'b1;
    #1;
    check("t5_rst_dec", 32'(dec_out), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rdy", 32'(code_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_rel_rdy", 32'(code_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_resume", 32'({busy, dec_out}), 32'd0);
    end
`ifdef PE_DEC_COUNT_EN
    check("t5_cnt2_clr", 32'(cnt2), 32'd0);
`endif

    // 6: HOLD_CYCLES=1, 300 back-to-back transfers of code 01
    pulses = 0;
    code_valid1 = 1'b1;
    for (int n = 0; n < 300; n++) begin
      waited = 0;
      while (!code_ready1 && waited < 8) begin
        tick();
        waited++;
      end
      if (!code_ready1) begin
        check("t6_ready_timeout", 32'(code_ready1), 32'd1);
        break;
      end
      tick();
      if (dec_out1 == 3'b001) pulses++;
      if (n == 0) begin
        code_valid1 = 1'b1;
        tick();
        check("t6_gap_dec", 32'(dec_out1), 32'd0);
        check("t6_gap_busy", 32'(busy1), 32'd1);
        check("t6_gap_rdy", 32'(code_ready1), 32'd0);
      end
    end
    code_valid1 = 1'b0;
    check("t6_pulses", 32'(pulses), 32'd300);
    tick();
    tick();
    check("t6_end_dec", 32'(dec_out1), 32'd0);
    check("t6_end_rdy", 32'(code_ready1), 32'd1);
`ifdef PE_DEC_COUNT_EN
    check("t6_cnt0_sat", 32'(c1_0), 32'd255);
    check("t6_cnt1", 32'(c1_1), 32'd0);
    check("t6_cnt2", 32'(c1_2), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
